// File: rtl/vertex_pe_mac.sv
// Pipelined GCN vertex-update PE: multiplies weight/feature pairs, reduces them in an adder tree,
// and accumulates NUM_CHUNKS beats into one saturated vertex value with valid/ready on both sides.
`timescale 1ns/1ps
module vertex_pe_mac #(
  parameter int MULT_PER_PE = 4,
  parameter int FV_SIZE     = 16,
  parameter int NODE_ID_W   = 8,
  parameter int NUM_CHUNKS  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MULT_PER_PE*FV_SIZE-1:0] Weight_data_in,
  input  logic [MULT_PER_PE*FV_SIZE-1:0] FV_RS,
  input  logic [NODE_ID_W-1:0]           Node_id,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [FV_SIZE-1:0]             Vertex_output,
  output logic [NODE_ID_W-1:0]           Node_id_out,
  output logic                           out_sat,
  output logic                           id_err
);

  localparam int PROD_W = 2 * FV_SIZE;
  localparam int LOG_M  = $clog2(MULT_PER_PE);
  localparam int SUM_W  = PROD_W + LOG_M;
  localparam int ACC_W  = PROD_W + $clog2(MULT_PER_PE * NUM_CHUNKS);
  localparam int CNT_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  logic                 stall;
  logic                 accept;
  logic                 first_beat;
  logic                 beat_last;
  logic [CNT_W-1:0]     chunk_cnt;
  logic [NODE_ID_W-1:0] grp_id;
  logic [NODE_ID_W-1:0] beat_id;

  logic                 s1_valid;
  logic                 s1_last;
  logic [NODE_ID_W-1:0] s1_id;
  logic [PROD_W-1:0]    s1_prod [MULT_PER_PE];

  logic                 s2_valid;
  logic                 s2_last;
  logic [NODE_ID_W-1:0] s2_id;
  logic [SUM_W-1:0]     s2_sum;
  logic [SUM_W-1:0]     tree_sum;

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     total;
  logic                 overflow;

  assign stall      = out_valid && !out_ready;
  assign in_ready   = !stall;
  assign accept     = in_valid && in_ready;
  assign first_beat = (chunk_cnt == '0);
  assign beat_last  = (chunk_cnt == LAST_CNT);
  assign beat_id    = first_beat ? Node_id : grp_id;

  // Group bookkeeping: the id of the first beat is what gets reported for the whole group.
  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_cnt <= '0;
      grp_id    <= '0;
      id_err    <= 1'b0;
    end else if (accept) begin
      chunk_cnt <= beat_last ? '0 : chunk_cnt + CNT_W'(1);
      if (first_beat) begin
        grp_id <= Node_id;
      end else if (Node_id != grp_id) begin
        id_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_id    <= '0;
      for (int i = 0; i < MULT_PER_PE; i++) begin
        s1_prod[i] <= '0;
      end
    end else if (!stall) begin
      s1_valid <= accept;
      s1_last  <= beat_last;
      s1_id    <= beat_id;
      for (int i = 0; i < MULT_PER_PE; i++) begin
        s1_prod[i] <= PROD_W'(Weight_data_in[i*FV_SIZE +: FV_SIZE]) *
                      PROD_W'(FV_RS[i*FV_SIZE +: FV_SIZE]);
      end
    end
  end

  // Binary reduction tree; each level keeps its own node array so levels stay acyclic.
  genvar lv, nd;
  generate
    for (lv = 0; lv <= LOG_M; lv++) begin : g_lvl
      logic [SUM_W-1:0] node [MULT_PER_PE >> lv];
      for (nd = 0; nd < (MULT_PER_PE >> lv); nd++) begin : g_node
        if (lv == 0) begin : g_leaf
          assign node[nd] = SUM_W'(s1_prod[nd]);
        end else begin : g_add
          assign node[nd] = g_lvl[lv-1].node[2*nd] + g_lvl[lv-1].node[2*nd+1];
        end
      end
    end
  endgenerate

  assign tree_sum = g_lvl[LOG_M].node[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_id    <= '0;
      s2_sum   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_id    <= s1_id;
      s2_sum   <= tree_sum;
    end
  end

  assign total    = acc + ACC_W'(s2_sum);
  assign overflow = |total[ACC_W-1:FV_SIZE];

  // When not stalled any held output has been consumed, so out_valid follows the new result only.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc           <= '0;
      out_valid     <= 1'b0;
      Vertex_output <= '0;
      Node_id_out   <= '0;
      out_sat       <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          acc           <= '0;
          Vertex_output <= overflow ? {FV_SIZE{1'b1}} : total[FV_SIZE-1:0];
          out_sat       <= overflow;
          Node_id_out   <= s2_id;
        end else begin
          acc <= total;
        end
      end
    end
  end

endmodule

// File: tb/tb_vertex_pe_mac.sv
// Scoreboard bench for vertex_pe_mac: directed groups push expected results, monitors pop on handshake.
`timescale 1ns/1ps
module tb_vertex_pe_mac;

  localparam int MP  = 4;
  localparam int FV  = 16;
  localparam int IDW = 8;
  localparam int NC  = 2;
  localparam int MPB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              in_valid, in_ready, out_valid, out_ready, out_sat, id_err;
  logic [MP*FV-1:0]  w_data, f_data;
  logic [IDW-1:0]    node_id, node_id_out;
  logic [FV-1:0]     vertex_output;

  logic              in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sat_b, id_err_b;
  logic [MPB*FV-1:0] w_data_b, f_data_b;
  logic [IDW-1:0]    node_id_b, node_id_out_b;
  logic [FV-1:0]     vertex_output_b;

  vertex_pe_mac #(.MULT_PER_PE(MP), .FV_SIZE(FV), .NODE_ID_W(IDW), .NUM_CHUNKS(NC)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Weight_data_in(w_data), .FV_RS(f_data), .Node_id(node_id),
    .out_valid(out_valid), .out_ready(out_ready), .Vertex_output(vertex_output),
    .Node_id_out(node_id_out), .out_sat(out_sat), .id_err(id_err)
  );

  vertex_pe_mac #(.MULT_PER_PE(MPB), .FV_SIZE(FV), .NODE_ID_W(IDW), .NUM_CHUNKS(1)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .Weight_data_in(w_data_b), .FV_RS(f_data_b), .Node_id(node_id_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .Vertex_output(vertex_output_b),
    .Node_id_out(node_id_out_b), .out_sat(out_sat_b), .id_err(id_err_b)
  );

  typedef struct {
    logic [FV-1:0]  val;
    logic [IDW-1:0] id;
    logic           sat;
    logic           err;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb_b[$];

  int cyc       = 0;
  int pass_cnt  = 0;
  int check_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [MP*FV-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[FV-1:0], c[FV-1:0], b[FV-1:0], a[FV-1:0]};
  endfunction

  // Presents one beat and returns the cycle in which it was accepted.
  task automatic applyStimulus(input logic [MP*FV-1:0] w, input logic [MP*FV-1:0] f,
                               input logic [IDW-1:0] id, output int acc_cyc);
    int waited = 0;
    w_data   = w;
    f_data   = f;
    node_id  = id;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check_cnt++;
        $display("[TB] FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc - 1;
    in_valid = 1'b0;
  endtask

  task automatic sendGroup(input logic [MP*FV-1:0] w1, input logic [MP*FV-1:0] f1,
                           input logic [MP*FV-1:0] w2, input logic [MP*FV-1:0] f2,
                           input logic [IDW-1:0] id1, input logic [IDW-1:0] id2,
                           input logic [FV-1:0] ev, input logic [IDW-1:0] eid,
                           input logic es, input logic ee, input bit chk_lat);
    int   c;
    exp_t e;
    applyStimulus(w1, f1, id1, c);
    applyStimulus(w2, f2, id2, c);
    e.val = ev; e.id = eid; e.sat = es; e.err = ee;
    e.cyc = chk_lat ? c + 3 : -1;
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || sb_b.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sb_drained", sb.size() + sb_b.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_vertex_output", vertex_output, 0);
    checkOutput("rst_node_id_out", node_id_out, 0);
    checkOutput("rst_out_sat", out_sat, 0);
    checkOutput("rst_id_err", id_err, 0);
    checkOutput("rst_in_ready", in_ready, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL unexpected_output: got value 0x%0h id %0d, expected no output", vertex_output, node_id_out);
      end else begin
        e = sb.pop_front();
        checkOutput("vertex_output", vertex_output, e.val);
        checkOutput("node_id_out", node_id_out, e.id);
        checkOutput("out_sat", out_sat, e.sat);
        checkOutput("id_err", id_err, e.err);
        if (e.cyc >= 0) checkOutput("latency_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid_b && out_ready_b) begin
      if (sb_b.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL unexpected_output_b: got value 0x%0h id %0d, expected no output", vertex_output_b, node_id_out_b);
      end else begin
        e = sb_b.pop_front();
        checkOutput("vertex_output_b", vertex_output_b, e.val);
        checkOutput("node_id_out_b", node_id_out_b, e.id);
        checkOutput("out_sat_b", out_sat_b, e.sat);
        checkOutput("latency_cycle_b", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [MP*FV-1:0] wb1, fb1, wb2, fb2, ones, zero;
    exp_t e;
    int   c;

    wb1  = pack4(1, 2, 3, 4);
    fb1  = pack4(5, 6, 7, 8);
    wb2  = pack4(1, 1, 1, 1);
    fb2  = pack4(10, 10, 10, 10);
    ones = {MP{16'hFFFF}};
    zero = '0;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    w_data = '0; f_data = '0; node_id = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    w_data_b = '0; f_data_b = '0; node_id_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkResetState();
    checkOutput("rst_out_valid_b", out_valid_b, 0);
    @(posedge clk);
    #1;

    // 70 + 40 = 110, with a three-cycle latency check
    sendGroup(wb1, fb1, wb2, fb2, 8'd7, 8'd7, 16'h006E, 8'd7, 1'b0, 1'b0, 1'b1);
    // Saturating group immediately followed by an all-zero group
    sendGroup(ones, ones, ones, ones, 8'd9, 8'd9, 16'hFFFF, 8'd9, 1'b1, 1'b0, 1'b1);
    sendGroup(zero, zero, zero, zero, 8'd10, 8'd10, 16'h0000, 8'd10, 1'b0, 1'b0, 1'b1);
    waitDrain();

    // Backpressure: hold the first result for five cycles while four groups stream in
    out_ready = 1'b0;
    fork
      begin
        sendGroup(wb1, fb1, wb2, fb2, 8'd7, 8'd7, 16'd110, 8'd7, 1'b0, 1'b0, 1'b0);
        sendGroup(wb2, wb2, wb2, wb2, 8'd20, 8'd20, 16'd8, 8'd20, 1'b0, 1'b0, 1'b0);
        sendGroup(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), pack4(2, 2, 2, 2), pack4(3, 3, 3, 3),
                  8'd21, 8'd21, 16'd48, 8'd21, 1'b0, 1'b0, 1'b0);
        sendGroup(pack4(10, 0, 0, 0), pack4(10, 0, 0, 0), pack4(0, 0, 0, 1), pack4(0, 0, 0, 5),
                  8'd22, 8'd22, 16'd105, 8'd22, 1'b0, 1'b0, 1'b0);
      end
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 100);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          checkOutput("stall_in_ready", in_ready, 0);
          checkOutput("stall_out_valid", out_valid, 1);
          checkOutput("stall_hold_value", vertex_output, 16'd110);
          checkOutput("stall_hold_id", node_id_out, 8'd7);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset in the middle of a group discards the partial sum
    applyStimulus(wb1, fb1, 8'd3, c);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    sendGroup(wb1, fb1, wb2, fb2, 8'd4, 8'd4, 16'd110, 8'd4, 1'b0, 1'b0, 1'b1);
    waitDrain();

    // Id changes mid-group: flagged, captured id reported, sum unaffected
    sendGroup(wb1, fb1, wb2, fb2, 8'd5, 8'd6, 16'd110, 8'd5, 1'b0, 1'b1, 1'b1);
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("id_err_sticky", id_err, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("id_err_cleared", id_err, 0);
    @(posedge clk);
    #1;

    // Single-chunk, eight-multiplier instance: 8 * 2 * 3 = 48 every cycle
    w_data_b = {MPB{16'd2}};
    f_data_b = {MPB{16'd3}};
    for (int i = 0; i < 8; i++) begin
      node_id_b  = IDW'(48 + i);
      in_valid_b = 1'b1;
      @(negedge clk);
      checkOutput("in_ready_b", in_ready_b, 1);
      @(posedge clk);
      #1;
      e.val = 16'd48; e.id = IDW'(48 + i); e.sat = 1'b0; e.err = 1'b0;
      e.cyc = cyc - 1 + 3;
      sb_b.push_back(e);
    end
    in_valid_b = 1'b0;
    waitDrain();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/vertex_pe_mac.md
Name: vertex_pe_mac

Overview:
- Parametrised, pipelined vertex-update processing element for the GCN accelerator.
- Each accepted beat multiplies MULT_PER_PE weight/feature pairs and reduces the products through a full adder tree.
- Partial sums are accumulated over NUM_CHUNKS beats, so one output vertex value covers NUM_CHUNKS*MULT_PER_PE terms.
- It sits between the weight buffer / feature reservation station and the vertex output buffer, with valid/ready handshakes on both sides.

Parameters:
MULT_PER_PE, 4, multipliers per PE (power of two, >=2)
FV_SIZE, 16, feature/weight element width, unsigned
NODE_ID_W, 8, node id width
NUM_CHUNKS, 2, input beats accumulated per output vertex (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  PE can accept beat
Weight_data_in  input  MULT_PER_PE*FV_SIZE  packed weights, element i at [i*FV_SIZE +: FV_SIZE]
FV_RS  input  MULT_PER_PE*FV_SIZE  packed features, same packing
Node_id  input  NODE_ID_W  node id of beat
out_valid  output  1  Vertex_output valid
out_ready  input  1  downstream accepts output
Vertex_output  output  FV_SIZE  accumulated vertex value, saturated
Node_id_out  output  NODE_ID_W  node id of Vertex_output
out_sat  output  1  Vertex_output was clipped
id_err  output  1  sticky: Node_id changed within a chunk group

Behaviour:
- Reset: one clock; the polarity and synchronous behaviour are fixed as stated.
  - All outputs are 0, with in_ready=1 on the first cycle after reset.
  - All pipeline valids, the accumulator, the chunk counter and id_err clear.
  - Reset mid-group discards partial sums; no output is produced for that group.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - stall = out_valid && !out_ready; in_ready = !stall.
  - On stall, every pipeline stage, the accumulator and the outputs hold.
  - Outputs are stable while out_valid && !out_ready.
  - Output is consumed when out_valid && out_ready; out_valid deasserts the next cycle unless a new result lands in the same cycle.
- Stage 1 (+1 cycle): registers MULT_PER_PE products, each 2*FV_SIZE bits, full precision. Also carries valid, node id and a last flag.
- Stage 2 (+2): registers the adder-tree sum of all products. Width is 2*FV_SIZE+clog2(MULT_PER_PE); no overflow is possible.
- Stage 3 (+3): the accumulator is 2*FV_SIZE+clog2(MULT_PER_PE*NUM_CHUNKS) bits wide.
  - Non-last beat: acc <= acc + sum.
  - Last beat: total = acc + sum.
    - Vertex_output <= total > 2^FV_SIZE-1 ? 2^FV_SIZE-1 : total[FV_SIZE-1:0].
    - out_sat <= (total > 2^FV_SIZE-1).
    - Node_id_out <= group id; out_valid <= 1; acc <= 0.
- Chunk counter:
  - Counts accepted beats 0..NUM_CHUNKS-1 and wraps to 0 on the last beat.
  - The last flag is set when count == NUM_CHUNKS-1.
  - With NUM_CHUNKS=1, every beat is last and the PE acts as a pure 3-stage dot product.
- Node id:
  - Captured on the first beat of a group (count==0).
  - On a later beat with a different Node_id, id_err sets and stays set until reset. The accumulation continues and the captured id is reported.
- Latency and throughput:
  - Last beat accepted at cycle T gives out_valid at T+3.
  - Throughput is 1 beat/cycle with no bubbles when out_ready=1.
- Boundary cases:
  - Zero operands produce 0 with out_sat=0.
  - Back-to-back groups need no idle cycle.
  - A consumed output and a new result in the same cycle: the new result loads and out_valid stays 1.

Test Plan:
- Basic dot product (NUM_CHUNKS=2): beat1 W={1,2,3,4}, F={5,6,7,8}, id=7; beat2 W={1,1,1,1}, F={10,10,10,10}, id=7 -> out_valid 3 cycles after beat2, Vertex_output=0x006E (110), Node_id_out=7, out_sat=0, id_err=0.
- Saturation: two beats of all 0xFFFF weights and features -> Vertex_output=0xFFFF, out_sat=1. Next group with all operands 0 -> 0x0000, out_sat=0.
- Backpressure: stream 4 groups continuously with out_ready=0 for 5 cycles after the first out_valid.
  - in_ready=0 throughout the stall, and the output holds 110 / id 7.
  - After release, all 4 results appear in order with no loss or duplication.
- Reset mid-group: accept beat1 (id=3), assert reset one cycle, then send a full new group (id=4, beats as in the basic test).
  - The only output is 110 with id 4.
  - All outputs read 0 and in_ready=1 on the cycle after reset.
- Id mismatch: beat1 id=5, beat2 id=6 -> id_err=1 sticky, Node_id_out=5, value accumulated normally.
- NUM_CHUNKS=1, MULT_PER_PE=8 build: W=all 2, F=all 3 at 1 beat/cycle -> every output is 48, 3-cycle latency, one output per cycle.
